// File: rtl/lut_cfg_loader_if.sv
// lut_cfg_loader_if: bitstream handshake and tile-facing commit bus of the LUT configuration loader.
interface lut_cfg_loader_if #(parameter int CFG_W = 33);
    logic             start;
    logic             bs_valid;
    logic             bs_data;
    logic             bs_ready;
    logic [CFG_W-1:0] config_out;
    logic             cen;
    logic             busy;
    logic             done;
    logic             err;
    modport master (output start, bs_valid, bs_data, input bs_ready, config_out, cen, busy, done, err);
    modport slave (input start, bs_valid, bs_data, output bs_ready, config_out, cen, busy, done, err);
endinterface

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: MSB-first bit-serial loader for a fracturable LUT tile; commits the word with a one-cycle cen.
// LUT_CFG_PARITY_EN adds a trailing even-parity beat checked before commit.
module lut_cfg_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS,
    parameter int CFG_W    = 2*MEM_SIZE+1,
    parameter int CNT_W    = $clog2(CFG_W+1)
) (
    input logic             cclk,
    input logic             crst_n,
    lut_cfg_loader_if.slave bus
);
`ifdef LUT_CFG_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`endif
    state_t           state_q, state_d;
    logic [CFG_W-1:0] sreg_q, sreg_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cen_q, cen_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fire;
    assign bus.bs_ready   = state_q == SHIFT
`ifdef LUT_CFG_PARITY_EN
                          || state_q == CHECK
`endif
                          ;
    assign bus.config_out = cfg_q;
    assign bus.cen        = cen_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign fire           = bus.bs_valid && bus.bs_ready;
    // cen is registered out of LOAD so config_out is already stable for the whole strobe.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        cen_d   = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (fire) begin
                    sreg_d = {sreg_q[CFG_W-2:0], bus.bs_data};
                    cnt_d  = cnt_q + 1'b1;
`ifdef LUT_CFG_PARITY_EN
                    state_d = cnt_q == CNT_W'(CFG_W-1) ? CHECK : SHIFT;
`else
                    state_d = cnt_q == CNT_W'(CFG_W-1) ? LOAD : SHIFT;
`endif
                end
            end
`ifdef LUT_CFG_PARITY_EN
            CHECK: begin
                if (fire) begin
                    state_d = (^sreg_q ^ bus.bs_data) ? IDLE : LOAD;
                    err_d   = ^sreg_q ^ bus.bs_data;
                end
            end
`endif
            LOAD: begin
                cfg_d   = sreg_q;
                cen_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cfg_q   <= '0;
            cnt_q   <= '0;
            cen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            cen_q   <= cen_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: randomized self-checking bench; a tile stand-in captures config_out on cen.
module tb_lut_cfg_loader;
    localparam int CFG_W = 33;
`ifdef LUT_CFG_PARITY_EN
    localparam int NB = CFG_W + 1;
`else
    localparam int NB = CFG_W;
`endif
    logic cclk = 1'b0;
    logic crst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic tx_q[$];
    logic [CFG_W-1:0] tile_cfg = '0;
    lut_cfg_loader_if #(.CFG_W(CFG_W)) bus ();
    lut_cfg_loader dut (.cclk(cclk), .crst_n(crst_n), .bus(bus));
    always #5 cclk = ~cclk;
    always @(posedge cclk) if (bus.cen) tile_cfg <= bus.config_out;

    function automatic logic [1:0] tile_out(input logic [CFG_W-1:0] c, input int a);
        return c[CFG_W-1] ? {c[16+a], c[a]} : {c[a], c[a]};
    endfunction

    task automatic build(input logic [CFG_W-1:0] w, input logic flip);
        tx_q = {};
        for (int i = CFG_W-1; i >= 0; i--) tx_q.push_back(w[i]);
`ifdef LUT_CFG_PARITY_EN
        tx_q.push_back((^w) ^ flip);
`else
        if (flip) tx_q.push_back(1'b0);
`endif
    endtask

    // k counts cycles after the edge that accepted the final beat
    task automatic run_load(input int duty, input int poke_at, output int xfers, output int cens, output int lat);
        int budget;
        bit fire;
        xfers = 0; cens = 0; lat = 0; budget = 0;
        bus.start = 1'b1;
        @(posedge cclk); #1;
        bus.start = 1'b0;
        while (xfers < tx_q.size() && budget < 2000) begin
            bus.bs_valid = $urandom_range(99) < duty;
            bus.bs_data  = tx_q[xfers];
            bus.start    = xfers == poke_at;
            @(negedge cclk);
            fire = bus.bs_valid && bus.bs_ready;
            if (bus.cen) cens++;
            @(posedge cclk); #1;
            if (fire) xfers++;
            budget++;
        end
        bus.bs_valid = 1'b0;
        bus.start = 1'b0;
        if (budget >= 2000) begin
            tests++; fails++;
            $display("FAIL load_timeout: got %0d beats, expected %0d", xfers, tx_q.size());
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge cclk);
            if (bus.cen) begin
                cens++;
                if (lat == 0) lat = k;
            end
            @(posedge cclk); #1;
        end
    endtask

    task automatic test_reset();
        int cens;
        logic [CFG_W-1:0] w;
        tests++;
        if ({bus.config_out, bus.cen, bus.busy, bus.done, bus.err, bus.bs_ready} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h, expected 0", {bus.config_out, bus.cen, bus.busy, bus.done, bus.err, bus.bs_ready});
        end
        crst_n = 1'b1;
        @(posedge cclk); #1;
        bus.start = 1'b1;
        @(posedge cclk); #1;
        bus.start = 1'b0;
        bus.bs_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.bs_data = 1'($urandom);
            @(posedge cclk); #1;
        end
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL busy_mid_shift: got %b, expected 1", bus.busy); end
        crst_n = 1'b0;
        #1;
        tests++;
        if ({bus.config_out, bus.cen, bus.busy, bus.done, bus.err, bus.bs_ready} !== '0) begin
            fails++; $display("FAIL reset_mid_shift: got %h, expected 0", {bus.config_out, bus.cen, bus.busy, bus.done, bus.err, bus.bs_ready});
        end
        cens = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge cclk);
            if (bus.cen) cens++;
        end
        @(posedge cclk); #1;
        crst_n = 1'b1;
        bus.bs_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge cclk);
            if (bus.cen) cens++;
        end
        @(posedge cclk); #1;
        tests++;
        if (cens !== 0) begin fails++; $display("FAIL reset_no_cen: got %0d cen cycles, expected 0", cens); end
        w = {1'($urandom), $urandom()};
        build(w, 1'b0);
        begin
            int x, c, l;
            run_load(100, -1, x, c, l);
            tests++;
            if (bus.config_out !== w || c !== 1 || bus.done !== 1'b1) begin
                fails++; $display("FAIL reset_fresh_load: got cfg=%h cen=%0d done=%b, expected cfg=%h cen=1 done=1", bus.config_out, c, bus.done, w);
            end
        end
    endtask

    task automatic test_load();
        int x, c, l;
        logic [CFG_W-1:0] w;
        w = 33'h1_A5A5_3C3C;
        build(w, 1'b0);
        run_load(100, -1, x, c, l);
        tests++;
        if (x !== NB) begin fails++; $display("FAIL load_beats: got %0d, expected %0d", x, NB); end
        tests++;
        if (c !== 1) begin fails++; $display("FAIL load_cen_width: got %0d, expected 1", c); end
        tests++;
        if (l !== 2) begin fails++; $display("FAIL load_latency: got %0d, expected 2", l); end
        tests++;
        if (bus.config_out !== w) begin fails++; $display("FAIL load_config: got %h, expected %h", bus.config_out, w); end
        tests++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL load_flags: got done=%b err=%b busy=%b, expected 1 0 0", bus.done, bus.err, bus.busy);
        end
    endtask

    task automatic test_stalls();
        int x, c, l;
        logic [CFG_W-1:0] w;
        w = 33'h0_FFFF_0001;
        build(w, 1'b0);
        run_load(50, -1, x, c, l);
        tests++;
        if (x !== NB || c !== 1 || l !== 2) begin
            fails++; $display("FAIL stall_timing: got beats=%0d cen=%0d lat=%0d, expected %0d 1 2", x, c, l, NB);
        end
        tests++;
        if (bus.config_out !== w) begin fails++; $display("FAIL stall_config: got %h, expected %h", bus.config_out, w); end
    endtask

    task automatic test_random();
        int x, c, l;
        logic [CFG_W-1:0] w;
        for (int n = 0; n < 6; n++) begin
            w = {1'($urandom), $urandom()};
            build(w, 1'b0);
            run_load(int'($urandom_range(100, 30)), -1, x, c, l);
            tests++;
            if (bus.config_out !== w || c !== 1 || l !== 2 || x !== NB) begin
                fails++; $display("FAIL random_load_%0d: got cfg=%h cen=%0d lat=%0d, expected cfg=%h cen=1 lat=2", n, bus.config_out, c, l, w);
            end
        end
    endtask

    task automatic test_misuse();
        int x, c, l, bad_ready, cens;
        logic [CFG_W-1:0] prev, w;
        prev = bus.config_out;
        bad_ready = 0; cens = 0;
        bus.bs_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.bs_data = 1'($urandom);
            @(negedge cclk);
            if (bus.bs_ready) bad_ready++;
            if (bus.cen) cens++;
            @(posedge cclk); #1;
        end
        bus.bs_valid = 1'b0;
        tests++;
        if (bad_ready !== 0 || cens !== 0) begin
            fails++; $display("FAIL idle_valid: got ready=%0d cen=%0d, expected 0 0", bad_ready, cens);
        end
        tests++;
        if (bus.config_out !== prev || bus.busy !== 1'b0) begin
            fails++; $display("FAIL idle_config: got %h busy=%b, expected %h busy=0", bus.config_out, bus.busy, prev);
        end
        w = {1'($urandom), $urandom()};
        build(w, 1'b0);
        run_load(70, 10, x, c, l);
        tests++;
        if (x !== NB || c !== 1 || bus.config_out !== w) begin
            fails++; $display("FAIL start_while_busy: got beats=%0d cen=%0d cfg=%h, expected %0d 1 %h", x, c, bus.config_out, NB, w);
        end
    endtask

    task automatic test_tile();
        int x, c, l;
        logic [CFG_W-1:0] w;
        logic [1:0] exp;
        for (int s = 0; s < 2; s++) begin
            w = {1'(s), $urandom()};
            build(w, 1'b0);
            run_load(80, -1, x, c, l);
            for (int a = 0; a < 16; a++) begin
                exp = s ? {w[16+a], w[a]} : {w[a], w[a]};
                tests++;
                if (tile_out(tile_cfg, a) !== exp) begin
                    fails++; $display("FAIL tile_split%0d_addr%0d: got %b, expected %b", s, a, tile_out(tile_cfg, a), exp);
                end
            end
        end
    endtask

`ifdef LUT_CFG_PARITY_EN
    task automatic test_parity();
        int x, c, l;
        logic [CFG_W-1:0] w, prev;
        w = {1'($urandom), $urandom()};
        build(w, 1'b0);
        run_load(60, -1, x, c, l);
        tests++;
        if (c !== 1 || l !== 2 || bus.err !== 1'b0 || bus.config_out !== w) begin
            fails++; $display("FAIL parity_good: got cen=%0d lat=%0d err=%b cfg=%h, expected 1 2 0 %h", c, l, bus.err, bus.config_out, w);
        end
        prev = w;
        w = ~w;
        build(w, 1'b1);
        run_load(60, -1, x, c, l);
        tests++;
        if (c !== 0 || bus.err !== 1'b1 || bus.done !== 1'b0 || bus.config_out !== prev) begin
            fails++; $display("FAIL parity_bad: got cen=%0d err=%b done=%b cfg=%h, expected 0 1 0 %h", c, bus.err, bus.done, bus.config_out, prev);
        end
        build(w, 1'b0);
        run_load(100, -1, x, c, l);
        tests++;
        if (c !== 1 || bus.err !== 1'b0 || bus.config_out !== w) begin
            fails++; $display("FAIL parity_recover: got cen=%0d err=%b cfg=%h, expected 1 0 %h", c, bus.err, bus.config_out, w);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.bs_valid = 1'b0;
        bus.bs_data = 1'b0;
        repeat (2) @(posedge cclk);
        #1;
        test_reset();
        test_load();
        test_stalls();
        test_random();
        test_misuse();
        test_tile();
`ifdef LUT_CFG_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
